fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Drain stage directly downstream of the 4-deep byte FIFO.
- Pops one byte at a time through the FIFO read interface (rd_en / data_out / empty) and serialises it as an 8N1 UART frame on a single output line.
- Sits between the FIFO and the board TX pin. It is the only consumer of the FIFO read side.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535; bench uses 4
DATA_W, 8, byte width; fixed at 8, parameter is for documentation only

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
tx_en  input  1  permission to start new frames; a frame already in flight always completes
fifo_empty  input  1  FIFO empty flag
fifo_data  input  8  FIFO data_out; valid the cycle after rd_en is high
fifo_rd_en  output  1  pop request to FIFO; high for exactly one cycle per byte
tx  output  1  serial line, idle high, registered
busy  output  1  high in every state other than IDLE
frame_done  output  1  one-cycle pulse in the last cycle of the stop bit

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0.
  - Bit counter, baud counter and shift register cleared.
  - A byte in flight is lost; it is not re-popped.
- States: IDLE, POP, LOAD, START, DATA, STOP (plus PARITY with option).
- IDLE -> POP when tx_en=1 and fifo_empty=0, sampled on the clock edge.
- POP: fifo_rd_en=1, decoded combinationally from state==POP. Lasts exactly one cycle, then LOAD.
- LOAD: shift register <= fifo_data (FIFO has updated data_out at the POP edge), then START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each. The shift register shifts right at each bit boundary.
- STOP: tx=1 for CLKS_PER_BIT cycles; frame_done=1 in its final cycle.
- Exit from STOP: if tx_en=1 and fifo_empty=0, go directly to POP; otherwise go to IDLE.
- tx timing: tx is a register updated on the edge that enters each bit state, so tx changes on the first cycle of START/DATA/STOP.
- Frame timing:
  - Frame = 10*CLKS_PER_BIT cycles of start+data+stop.
  - Minimum inter-frame idle-high gap = 2 cycles (POP+LOAD).
- Baud counter: counts 0..CLKS_PER_BIT-1 and is reset to 0 on every state entry. Width is $clog2(CLKS_PER_BIT).
- Bit counter: 3 bits; DATA exits when the counter reaches 7 and the baud counter is at terminal count.
- Boundary rules:
  - fifo_rd_en is never asserted while fifo_empty=1 or tx_en=0.
  - If fifo_empty rises during a frame, there is no effect until the STOP exit decision.
  - If tx_en drops mid-frame, the frame completes and no new pop occurs.
  - If tx_en and fifo_empty change in the same cycle, only the values sampled at the decision edge matter.
- Latency: from fifo_empty falling (with IDLE and tx_en=1), tx falls 3 clocks later (IDLE->POP->LOAD->START).

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of 8 data bits) for CLKS_PER_BIT cycles.
  - Frame = 11*CLKS_PER_BIT cycles.
- Undefined:
  - No PARITY state and no parity logic.
  - Frame = 10*CLKS_PER_BIT cycles.

Decomposition:
- Package fifo_uart_pkg holds:
  - state encoding typedef (3-bit enum: IDLE, POP, LOAD, START, DATA, PARITY, STOP)
  - constant TX_IDLE_LEVEL=1'b1
  - constant DATA_BITS=8
- One sub-module, uart_bit_timer:
  - parameter CLKS_PER_BIT
  - inputs clk, rstn, restart
  - output bit_tick, high on the last cycle of each bit period
- The FSM and shift register stay in fifo_uart_tx.

Test Plan:
1. Reset asserted with FIFO non-empty -> tx=1, fifo_rd_en=0, busy=0 throughout; no pop after 20 cycles with rstn=0.
2. CLKS_PER_BIT=4, single byte 0xA5, tx_en=1:
   - exactly one 1-cycle fifo_rd_en pulse
   - tx bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles)
   - frame_done pulses once, in cycle 40 of the frame
   - then busy=0
3. Bytes 0x01,0x02,0x03 queued:
   - three rd_en pulses total
   - each pair of frames separated by exactly 2 idle-high cycles
   - captured bytes match in order
   - no rd_en once fifo_empty=1
4. tx_en=0 with FIFO non-empty for 50 cycles -> no rd_en, tx=1. tx_en deasserted mid-data-bit of frame 1 -> frame 1 completes intact, no second pop.
5. rstn pulsed low during DATA bit 3:
   - tx=1 immediately (asynchronously), busy=0
   - after release with FIFO non-empty, the next byte is popped and sent as a complete frame
6. FIFO_UART_TX_PARITY_EN defined, byte 0x07 -> parity bit=1, frame=44 cycles at CLKS_PER_BIT=4. Byte 0x03 -> parity bit=0.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed 8N1 UART transmitter.
package fifo_uart_pkg;

    localparam int unsigned DATA_BITS     = 8;
    localparam logic        TX_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter: counts 0..CLKS_PER_BIT-1, flags the last cycle of each bit period.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic restart,
    output logic bit_tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || bit_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the upstream FIFO and serialises them as 8N1 UART frames.
// Optional even parity bit is enabled by defining FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [2:0]        bit_cnt_q;
    logic [2:0]        bit_cnt_d;
    logic              tx_q;
    logic              tx_d;
    logic              bit_tick;
    logic              restart;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              parity_q;
    logic              parity_d;
`endif

    // Baud counter restarts on every state entry so each bit state gets a full period.
    assign restart = (state_d != state_q);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rstn    (rstn),
        .restart (restart),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (tx_en && !fifo_empty) state_d = S_POP;
            S_POP:   state_d = S_LOAD;
            S_LOAD:  state_d = S_START;
            S_START: if (bit_tick) state_d = S_DATA;
            S_DATA: begin
                if (bit_tick && (bit_cnt_q == 3'(DATA_BITS - 1))) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: if (bit_tick) state_d = S_STOP;
`endif
            // Back-to-back frames skip IDLE; the decision uses only this edge's inputs.
            S_STOP: begin
                if (bit_tick) begin
                    state_d = (tx_en && !fifo_empty) ? S_POP : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_en = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        fifo_rd_en = (state_q == S_POP);
        busy       = (state_q != S_IDLE);
        frame_done = (state_q == S_STOP) && bit_tick;
    end

    // Datapath: tx is computed from the next state so it changes on bit-state entry.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = TX_IDLE_LEVEL;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state_q == S_LOAD) begin
            shift_d   = fifo_data;
            bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_d  = ^fifo_data;
`endif
        end else if ((state_q == S_DATA) && bit_tick) begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_q;
`endif
            default:  tx_d = TX_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= TX_IDLE_LEVEL;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural FIFO on its read side.
// Define FIFO_UART_TX_PARITY_EN to check the parity build.
module tb_fifo_uart_tx;

    localparam int unsigned CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int unsigned FB = 11;
`else
    localparam int unsigned FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       tx_en = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (8)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .tx_en     (tx_en),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural FIFO: data_out updates at the pop edge.
    logic [7:0] mem [256];
    int         wr_n = 0;
    int         rd_n = 0;
    logic       rd_prev = 1'b0;

    always_comb fifo_empty = (wr_n == rd_n);

    task automatic push(input logic [7:0] b);
        mem[8'(wr_n)] = b;
        wr_n++;
    endtask

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data <= mem[8'(rd_n)];
            rd_n      <= rd_n + 1;
        end
    end

    // Every pop must be legal and exactly one cycle wide.
    always @(negedge clk) begin
        if (fifo_rd_en) begin
            chk("rd_en_guard", 32'({tx_en, fifo_empty, rd_prev}), 32'b100);
        end
        rd_prev <= fifo_rd_en;
    end

    function automatic logic [10:0] fr(input logic [7:0] d, input logic p);
`ifdef FIFO_UART_TX_PARITY_EN
        return {1'b1, p, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    // Waits for the start bit, then checks gap, every bit, hold, busy and frame_done.
    task automatic check_frame(input string name, input logic [10:0] exp, input bit expect_idle);
        int          gap = 0;
        bit          found = 1'b0;
        int          bad = 0;
        int          fd_bad = 0;
        logic [10:0] got = '0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1'b1;
            else gap++;
        end
        chk({name, " start"}, 32'(found), 32'd1);
        if (found) begin
            chk({name, " gap"}, 32'(gap), 32'd2);
            for (int b = 0; b < int'(FB); b++) begin
                for (int c = 0; c < int'(CPB); c++) begin
                    if (c == 0) got[b] = tx;
                    else if (tx !== got[b]) bad++;
                    if (busy !== 1'b1) bad++;
                    if (frame_done !== ((b == int'(FB) - 1 && c == int'(CPB) - 1) ? 1'b1 : 1'b0)) fd_bad++;
                    if (!(b == int'(FB) - 1 && c == int'(CPB) - 1)) @(negedge clk);
                end
            end
            chk({name, " bits"}, 32'(got), 32'(exp));
            chk({name, " hold"}, 32'(bad), 32'd0);
            chk({name, " frame_done"}, 32'(fd_bad), 32'd0);
            if (expect_idle) begin
                @(negedge clk);
                chk({name, " idle"}, 32'({busy, tx}), 32'b01);
            end
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t tv [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        int r0;
        bit found;

        tv[0] = '{8'h00, 1'b0};
        tv[1] = '{8'hFF, 1'b0};
        tv[2] = '{8'h07, 1'b1};
        tv[3] = '{8'h03, 1'b0};
        tv[4] = '{8'h80, 1'b1};
        tv[5] = '{8'h3C, 1'b0};

        // Reset held with data waiting: nothing may move.
        tx_en = 1'b1;
        push(8'hA5);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        chk("reset hold", 32'(bad), 32'd0);
        chk("reset no pop", 32'(rd_n), 32'd0);

        // Single byte A5 right after reset release.
        r0 = rd_n;
        rstn = 1'b1;
        check_frame("A5", fr(8'hA5, 1'b0), 1'b1);
        chk("A5 pops", 32'(rd_n - r0), 32'd1);

        for (int i = 0; i < 6; i++) begin
            r0 = rd_n;
            push(tv[i].data);
            check_frame($sformatf("vec%0d", i), fr(tv[i].data, tv[i].par), 1'b1);
            chk($sformatf("vec%0d pops", i), 32'(rd_n - r0), 32'd1);
        end

        // Three queued bytes go out back to back with 2-cycle gaps.
        r0 = rd_n;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        check_frame("b2b 01", fr(8'h01, 1'b1), 1'b0);
        check_frame("b2b 02", fr(8'h02, 1'b1), 1'b0);
        check_frame("b2b 03", fr(8'h03, 1'b0), 1'b1);
        chk("b2b pops", 32'(rd_n - r0), 32'd3);
        chk("b2b empty", 32'(fifo_empty), 32'd1);

        // tx_en low blocks pops.
        tx_en = 1'b0;
        push(8'h55);
        push(8'h66);
        r0 = rd_n;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("tx_en low idle", 32'(bad), 32'd0);
        chk("tx_en low no pop", 32'(rd_n - r0), 32'd0);

        // tx_en drops mid data bit 1: frame completes, no second pop.
        tx_en = 1'b1;
        fork
            check_frame("drop 55", fr(8'h55, 1'b0), 1'b1);
            begin
                repeat (13) @(negedge clk);
                tx_en = 1'b0;
            end
        join
        chk("drop pops", 32'(rd_n - r0), 32'd1);
        repeat (20) @(negedge clk);
        chk("drop no late pop", 32'(rd_n - r0), 32'd1);
        chk("drop still queued", 32'(fifo_empty), 32'd0);

        // Async reset during data bit 3 of 0x66; 0x99 follows after release.
        push(8'h99);
        tx_en = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1'b1;
        end
        chk("rst start seen", 32'(found), 32'd1);
        repeat (17) @(negedge clk);
        chk("rst pre tx", 32'(tx), 32'd0);
        #1 rstn = 1'b0;
        #1 chk("rst async", 32'({tx, busy, fifo_rd_en}), 32'b100);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        check_frame("after rst 99", fr(8'h99, 1'b0), 1'b1);
        chk("after rst pops", 32'(rd_n - r0), 32'd3);
        chk("after rst empty", 32'(fifo_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
